// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler for the tone-generator pool
//
// Purpose:
//   Shares NUM_VOICES oscillators among incoming MIDI notes. Note-on picks an
//   already-sounding voice (retrigger), else the lowest free voice, else the
//   pool-full policy. Note-off releases the voice holding the note; allOff_i
//   releases everything. Each voice carries an age rank (0 = newest).
//
// Optional feature:
//   VOICE_STEAL_EN  defined     -> full pool steals the oldest active voice
//                   not defined -> full pool drops the note-on (dropStrb_o)
//
// Ports:
//   clk_i          in   system clock
//   nrst_i         in   asynchronous active-low reset
//   note_i         in   note number, valid with a strobe
//   noteOnStrb_i   in   one-cycle note-on strobe
//   noteOffStrb_i  in   one-cycle note-off strobe
//   allOff_i       in   level, releases all voices, overrides both strobes
//   voiceNote_o    out  note per voice, voice v at [v*NOTE_BITS +: NOTE_BITS]
//   voiceActive_o  out  gate per voice
//   voiceTrig_o    out  one-cycle pulse on the voice just (re)assigned
//   stealStrb_o    out  one-cycle pulse when an active voice was stolen
//   dropStrb_o     out  one-cycle pulse when a note-on was discarded

module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_BITS  = 8
) (
    input  logic                             clk_i,
    input  logic                             nrst_i,
    input  logic [NOTE_BITS-1:0]             note_i,
    input  logic                             noteOnStrb_i,
    input  logic                             noteOffStrb_i,
    input  logic                             allOff_i,
    output logic [NUM_VOICES*NOTE_BITS-1:0]  voiceNote_o,
    output logic [NUM_VOICES-1:0]            voiceActive_o,
    output logic [NUM_VOICES-1:0]            voiceTrig_o,
    output logic                             stealStrb_o,
    output logic                             dropStrb_o
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef logic [IW-1:0] rank_t;

    localparam rank_t RANK_MAX = rank_t'(NUM_VOICES - 1);

    logic [NOTE_BITS-1:0]  note_q [NUM_VOICES];
    logic [NOTE_BITS-1:0]  note_d [NUM_VOICES];
    rank_t                 rank_q [NUM_VOICES];
    rank_t                 rank_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic                  steal_q, steal_d;
    logic                  drop_q, drop_d;

    // Search results over the pool after the note-off of this cycle is applied.
    logic [NUM_VOICES-1:0] active_mid;
    logic                  hit, free, oldest_found, assign_en;
    logic [IW-1:0]         hit_idx, free_idx, oldest_idx, tgt_idx;
    rank_t                 oldest_rank, old_rank;

    always_comb begin
        note_d       = note_q;
        rank_d       = rank_q;
        active_d     = active_q;
        trig_d       = '0;
        steal_d      = 1'b0;
        drop_d       = 1'b0;
        active_mid   = active_q;
        hit          = 1'b0;
        hit_idx      = '0;
        free         = 1'b0;
        free_idx     = '0;
        oldest_found = 1'b0;
        oldest_idx   = '0;
        oldest_rank  = '0;
        assign_en    = 1'b0;
        tgt_idx      = '0;
        old_rank     = '0;

        // Note-off is applied first so a simultaneous note-on sees the freed voice.
        if (noteOffStrb_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && (note_q[v] == note_i)) begin
                    active_mid[v] = 1'b0;
                end
            end
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!hit && active_mid[v] && (note_q[v] == note_i)) begin
                hit     = 1'b1;
                hit_idx = IW'(v);
            end
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!free && !active_mid[v]) begin
                free     = 1'b1;
                free_idx = IW'(v);
            end
        end

        // Strict '>' keeps the lowest index on equal ranks.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_mid[v] && (!oldest_found || (rank_q[v] > oldest_rank))) begin
                oldest_found = 1'b1;
                oldest_rank  = rank_q[v];
                oldest_idx   = IW'(v);
            end
        end

        if (noteOnStrb_i) begin
            if (hit) begin
                assign_en = 1'b1;
                tgt_idx   = hit_idx;
            end else if (free) begin
                assign_en = 1'b1;
                tgt_idx   = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                assign_en = 1'b1;
                tgt_idx   = oldest_idx;
                steal_d   = 1'b1;
`else
                drop_d    = 1'b1;
`endif
            end
        end

        active_d = active_mid;

        if (assign_en) begin
            old_rank = rank_q[tgt_idx];
            // Voices at or below the old rank age by one. Out of reset every rank
            // is 0, so '<=' (rather than '<') lets never-assigned voices count as
            // older than assigned ones; once ranks form a permutation the two are
            // equivalent. Saturation keeps a tied top rank in range.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if ((IW'(v) != tgt_idx) && (rank_q[v] <= old_rank) && (rank_q[v] != RANK_MAX)) begin
                    rank_d[v] = rank_q[v] + rank_t'(1);
                end
            end
            rank_d[tgt_idx]   = '0;
            note_d[tgt_idx]   = note_i;
            active_d[tgt_idx] = 1'b1;
            trig_d[tgt_idx]   = 1'b1;
        end

        if (allOff_i) begin
            note_d   = note_q;
            rank_d   = rank_q;
            active_d = '0;
            trig_d   = '0;
            steal_d  = 1'b0;
            drop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                rank_q[v] <= '0;
            end
            active_q <= '0;
            trig_q   <= '0;
            steal_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                rank_q[v] <= rank_d[v];
            end
            active_q <= active_d;
            trig_q   <= trig_d;
            steal_q  <= steal_d;
            drop_q   <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note_out
        assign voiceNote_o[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
    end

    assign voiceActive_o = active_q;
    assign voiceTrig_o   = trig_q;
    // Without stealing, steal_d is never set, so this register stays at 0.
    assign stealStrb_o   = steal_q;
    assign dropStrb_o    = drop_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler that sits between the MIDI parser (note, note-on/note-off strobes) and the tone-generator voices. It shares a fixed pool of NUM_VOICES oscillators among incoming notes. It assigns each note-on to a voice, releases voices on the matching note-off, and handles pool exhaustion by stealing the oldest voice. It also tracks allocation age per voice.

Parameters:
NUM_VOICES, 4, number of voices in the pool (2..8)
NOTE_BITS, 8, width of note number (equals `MIDI_PAYLOAD_BITS)

Ports:
clk_i  in  1  system clock
nrst_i  in  1  reset; asynchronous, active-low
note_i  in  NOTE_BITS  note number; valid while a strobe is high
noteOnStrb_i  in  1  one-cycle note-on strobe
noteOffStrb_i  in  1  one-cycle note-off strobe
allOff_i  in  1  level; clears all voices
voiceNote_o  out  NUM_VOICES*NOTE_BITS  note per voice; voice v at [v*NOTE_BITS +: NOTE_BITS]
voiceActive_o  out  NUM_VOICES  gate per voice
voiceTrig_o  out  NUM_VOICES  one-cycle pulse on the voice just (re)assigned
stealStrb_o  out  1  one-cycle pulse when an active voice was stolen
dropStrb_o  out  1  one-cycle pulse when a note-on was discarded (steal disabled and pool full)

Behaviour:
- Reset (async): voiceNote_o=0, voiceActive_o=0, voiceTrig_o=0, stealStrb_o=0, dropStrb_o=0, all age ranks=0.
- All outputs are registered. Latency is 1 cycle: a strobe sampled at edge N is reflected in the outputs after edge N.
- Age: each voice holds a rank 0..NUM_VOICES-1. Rank 0 is newest; the highest rank among active voices is oldest.
- On (re)assigning voice k with old rank r: rank[k]=0, and every voice with rank < r increments its rank. Ranks therefore always stay a permutation.
- Note-on priority, evaluated in one cycle:
  1. Note already active on voice k: retrigger k, meaning voiceTrig_o[k]=1 and k becomes newest. Never allocate a duplicate voice.
  2. Otherwise, take the lowest-index inactive voice: set note and active, pulse trig, rank update.
  3. Otherwise (pool full): steal per the optional feature.
- Note-off: clear voiceActive_o on the voice holding note_i. voiceNote_o keeps its value for release tails. Ranks are unchanged. A note-off for a note not held is ignored with no pulses.
- Note-on and note-off together: process the note-off first, then the note-on against the updated pool, all in the same cycle. The same note on both strobes ends active and retriggered.
- allOff_i=1 clears all voiceActive_o every cycle it is high and overrides both strobes. Notes and ranks are kept, and no pulses fire.
- voiceTrig_o, stealStrb_o and dropStrb_o are high for exactly one cycle per event and are otherwise 0.
- Reset asserted mid-operation clears everything immediately. The first strobe after release is handled normally.

Optional Feature:
Macro VOICE_STEAL_EN.
- Defined: on a full pool, the oldest active voice (highest rank) gets note_i. voiceTrig_o for that voice and stealStrb_o=1 in the same cycle, then the rank update.
- Not defined: on a full pool the note-on is discarded. dropStrb_o=1 for one cycle, and no voice, note or rank changes. The stealStrb_o output port is still present and tied to 0.

Test Plan:
- Reset, then note-on 60, 62, 64 on consecutive strobes -> voices 0/1/2 hold 60/62/64, voiceActive_o=4'b0111, one voiceTrig_o pulse each on bits 0, 1, 2.
- Note-off 62, then note-on 67 -> voice 1 released, then reassigned to 67, voiceActive_o=4'b0111.
- With 60, 62, 64, 65 active, note-on 69:
  - VOICE_STEAL_EN defined -> voice 0 (oldest) becomes 69, stealStrb_o pulse, voiceTrig_o=4'b0001.
  - Not defined -> dropStrb_o pulse and no voice change.
- With 60 on voice 0 and 62 on voice 1, note-on 60 again -> voiceTrig_o=4'b0001 and no new voice. A following steal (pool filled with 64, 65, then note-on 70) takes voice 1 (62).
- Note-on 60 and note-off 60 strobed together -> voice stays active on 60 with a trig pulse. Note-off 50 (not held) -> no change, no pulses.
- allOff_i high for 1 cycle with 3 voices active and a simultaneous note-on 72 -> voiceActive_o=0, no trig. Async reset mid-sequence -> all outputs 0 without waiting for a clock edge.
